// File: rtl/note_sequencer.sv
// Note record/replay sequencer: owns the note RAM write pointer, times replay reads
// and arbitrates the tone path. Define LOOP_PLAYBACK_EN to replay continuously.
module note_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int KEY_W      = 8,
  parameter int NOTE_TICKS = 1250000,
  parameter int GAP_TICKS  = 125000
) (
  input  logic              clk_5MHz,
  input  logic              resetn,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              record,
  input  logic              erase,
  input  logic              play_all,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [KEY_W-1:0]  mem_wdata,
  input  logic [KEY_W-1:0]  mem_rdata,
  output logic [KEY_W-1:0]  note_out,
  output logic              note_valid,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  localparam int TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]   NOTE_LOAD = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0]   GAP_LOAD  = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W:0] CAP       = (ADDR_W+1)'(2**ADDR_W);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, PLAY, GAP} state_t;

  state_t            state, state_d;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_d, rd_nxt, cnt_d;
  logic [TW-1:0]     tick, tick_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [KEY_W-1:0]  mem_wdata_d, note_out_d;
  logic              mem_we_d, note_valid_d, busy_d, adv;

  assign rd_nxt = rd_ptr + (ADDR_W+1)'(1);

  always_comb begin
    state_d      = state;
    rd_ptr_d     = rd_ptr;
    tick_d       = tick;
    cnt_d        = count;
    mem_addr_d   = mem_addr;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata;
    note_out_d   = note_out;
    note_valid_d = 1'b0;
    busy_d       = busy;
    adv          = 1'b0;
    case (state)
      IDLE: begin
        if (play_all && count != '0) begin
          state_d    = FETCH;
          busy_d     = 1'b1;
          rd_ptr_d   = '0;
          mem_addr_d = '0;
        end else begin
          if (key_valid) begin
            note_out_d   = key_in;
            note_valid_d = 1'b1;
          end
          // erase beats a same-cycle record write
          if (erase && count != '0) begin
            cnt_d = count - (ADDR_W+1)'(1);
          end else if (record && key_valid && count != CAP) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = count[ADDR_W-1:0];
            mem_wdata_d = key_in;
            cnt_d       = count + (ADDR_W+1)'(1);
          end
        end
      end
      FETCH:   state_d = WAIT_RD;
      WAIT_RD: begin
        note_out_d   = mem_rdata;
        note_valid_d = (mem_rdata != '0);
        tick_d       = NOTE_LOAD;
        state_d      = PLAY;
      end
      PLAY: begin
        if (tick != '0) begin
          tick_d       = tick - TW'(1);
          note_valid_d = (note_out != '0);
        end else if (GAP_TICKS > 0) begin
          tick_d  = GAP_LOAD;
          state_d = GAP;
        end else begin
          adv = 1'b1;
        end
      end
      GAP: begin
        if (tick != '0) tick_d = tick - TW'(1);
        else            adv    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      rd_ptr_d = rd_nxt;
      if (rd_nxt == count) begin
`ifdef LOOP_PLAYBACK_EN
        rd_ptr_d   = '0;
        mem_addr_d = '0;
        state_d    = FETCH;
`else
        state_d = IDLE;
        busy_d  = 1'b0;
`endif
      end else begin
        mem_addr_d = rd_nxt[ADDR_W-1:0];
        state_d    = FETCH;
      end
    end

    if (stop && state != IDLE) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      note_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_5MHz) begin
    if (!resetn) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      tick       <= '0;
      count      <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      state      <= state_d;
      rd_ptr     <= rd_ptr_d;
      tick       <= tick_d;
      count      <= cnt_d;
      mem_addr   <= mem_addr_d;
      mem_we     <= mem_we_d;
      mem_wdata  <= mem_wdata_d;
      note_out   <= note_out_d;
      note_valid <= note_valid_d;
      busy       <= busy_d;
      full       <= (cnt_d == CAP);
      empty      <= (cnt_d == '0);
    end
  end
endmodule
